// File: rtl/gpr_file_pkg.sv
// Shared types and defaults for the general-purpose register file.
// Widths follow the project-wide DATA_WIDTH / GPRS_WIDTH macros when they are defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

package gpr_file_pkg;

    localparam int GPR_DATA_W  = `DATA_WIDTH;
    localparam int GPR_ID_W    = `GPRS_WIDTH;
    localparam int GPR_ZERO_ID = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } gpr_state_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its result is written back.
// x0 never becomes busy.
module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int ID_W     = GPR_ID_W,
    parameter int NUM_REGS = 2 ** ID_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            set_en,
    input  logic [ID_W-1:0] set_id,
    input  logic            clr_en,
    input  logic [ID_W-1:0] clr_id,
    input  logic [ID_W-1:0] rs1_id,
    input  logic [ID_W-1:0] rs2_id,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set is applied after clear: a newly issued producer supersedes the one retiring.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_en && (clr_id == ID_W'(i))) busy_d[i] = 1'b0;
            if (set_en && (set_id == ID_W'(i))) busy_d[i] = 1'b1;
        end
        busy_d[GPR_ZERO_ID] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_id];
    assign rs2_busy = busy_q[rs2_id];

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: writeback sink, two operand read ports with optional
// same-cycle forwarding, a debug read port, and a post-reset clear sweep.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ID_W     = GPR_ID_W,
    parameter int NUM_REGS = 2 ** ID_W,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sys_valid,
    output logic              o_sys_ready,
    input  logic              i_wbu_gpr_wr_en,
    input  logic [ID_W-1:0]   i_wbu_gpr_wr_id,
    input  logic [DATA_W-1:0] i_wbu_gpr_wr_data,
    input  logic [ID_W-1:0]   i_idu_rs1_id,
    input  logic [ID_W-1:0]   i_idu_rs2_id,
    output logic [DATA_W-1:0] o_gpr_rs1_data,
    output logic [DATA_W-1:0] o_gpr_rs2_data,
    output logic              o_gpr_rs1_busy,
    output logic              o_gpr_rs2_busy,
    input  logic              i_idu_issue_en,
    input  logic [ID_W-1:0]   i_idu_issue_id,
    input  logic [ID_W-1:0]   i_dbg_rd_id,
    output logic [DATA_W-1:0] o_dbg_rd_data,
    output logic              o_gpr_init_done
);

    localparam logic [ID_W-1:0] ZERO_ID = ID_W'(GPR_ZERO_ID);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REGS - 1);

    gpr_state_t      state_q, state_d;
    logic [ID_W-1:0] sweep_q, sweep_d;
    logic            run;
    logic            wr_acc;
    logic            fwd1, fwd2;
    logic            sb_busy1, sb_busy2;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + ID_W'(1);
                if (sweep_q == LAST_ID) begin
                    state_d = RUN;
                    sweep_d = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign run             = (state_q == RUN);
    assign o_sys_ready     = run;
    assign o_gpr_init_done = run;

    // Handshake: a beat transfers when valid and ready are both high on a rising edge;
    // it only changes state when it is enabled and targets a register other than x0.
    assign wr_acc = i_sys_valid && o_sys_ready && i_wbu_gpr_wr_en
                    && (i_wbu_gpr_wr_id != ZERO_ID);

    // No reset on the array so it can map to memory; the sweep is its only clear path.
    always_ff @(posedge i_clk) begin
        if (!run) begin
            regs[sweep_q] <= '0;
        end else if (wr_acc) begin
            regs[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
        end
    end

    assign fwd1 = BYPASS && wr_acc && (i_wbu_gpr_wr_id == i_idu_rs1_id)
                  && (i_idu_rs1_id != ZERO_ID);
    assign fwd2 = BYPASS && wr_acc && (i_wbu_gpr_wr_id == i_idu_rs2_id)
                  && (i_idu_rs2_id != ZERO_ID);

    always_comb begin
        o_gpr_rs1_data = '0;
        o_gpr_rs2_data = '0;
        o_dbg_rd_data  = '0;
        if (run) begin
            if (i_idu_rs1_id != ZERO_ID) o_gpr_rs1_data = fwd1 ? i_wbu_gpr_wr_data : regs[i_idu_rs1_id];
            if (i_idu_rs2_id != ZERO_ID) o_gpr_rs2_data = fwd2 ? i_wbu_gpr_wr_data : regs[i_idu_rs2_id];
            if (i_dbg_rd_id != ZERO_ID)  o_dbg_rd_data  = regs[i_dbg_rd_id];
        end
    end

    gpr_scoreboard #(
        .ID_W     (ID_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .set_en   (run && i_idu_issue_en),
        .set_id   (i_idu_issue_id),
        .clr_en   (wr_acc),
        .clr_id   (i_wbu_gpr_wr_id),
        .rs1_id   (i_idu_rs1_id),
        .rs2_id   (i_idu_rs2_id),
        .rs1_busy (sb_busy1),
        .rs2_busy (sb_busy2)
    );

    // A forwarded operand is already available, so it is not reported as pending.
    assign o_gpr_rs1_busy = run && sb_busy1 && !fwd1;
    assign o_gpr_rs2_busy = run && sb_busy2 && !fwd2;

endmodule
